// File: rtl/hqm_event_balance_ctrl.sv
// hqm_event_balance_ctrl
// Tracks per-channel outstanding events (starts minus ends). On request it
// waits up to a programmable number of cycles for every channel to drain,
// then reports pass/fail with a per-channel failure mask. Dropped or
// duplicated events are flagged in sticky underflow/overflow masks.
module hqm_event_balance_ctrl #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int TMO_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] in_event,
   input  logic [NUM_CH-1:0] out_event,
   input  logic              chk_req,
   input  logic [TMO_W-1:0]  chk_timeout,
   input  logic              err_clr,
   output logic              chk_busy,
   output logic              chk_ack,
   output logic              chk_pass,
   output logic [NUM_CH-1:0] chk_fail_mask,
   output logic [NUM_CH-1:0] err_uflow,
   output logic [NUM_CH-1:0] err_oflow,
   output logic              outstanding_any
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRAIN  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [TMO_W-1:0]    r_timer;
   logic                r_pass;
   logic [NUM_CH-1:0]   r_fail_mask;
   logic [NUM_CH-1:0]   r_uflow;
   logic [NUM_CH-1:0]   r_oflow;

   logic [NUM_CH-1:0]   w_nonzero;
   logic [NUM_CH-1:0]   w_uflow_evt;
   logic [NUM_CH-1:0]   w_oflow_evt;
   logic                w_all_zero;
   logic                w_load_timer;
   logic                w_dec_timer;
   logic                w_done;
   logic                w_busy;
   logic                w_ack;
   logic [NUM_CH-1:0]   w_fail_mask;

   // Per-channel saturating outstanding counters and their error events.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
         logic [CNT_W-1:0] r_cnt;
         logic             w_inc_only;
         logic             w_dec_only;

         assign w_inc_only = in_event[gi] & ~out_event[gi];
         assign w_dec_only = out_event[gi] & ~in_event[gi];

         // Count moves by one unless it would wrap, in which case it holds.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= '0;
            end else if (w_inc_only && (r_cnt != {CNT_W{1'b1}})) begin
               r_cnt <= r_cnt + 1'b1;
            end else if (w_dec_only && (r_cnt != '0)) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end

         assign w_oflow_evt[gi] = w_inc_only & (r_cnt == {CNT_W{1'b1}});
         assign w_uflow_evt[gi] = w_dec_only & (r_cnt == '0);
         assign w_nonzero[gi]   = (r_cnt != '0);
      end
   endgenerate

   assign w_all_zero  = ~|w_nonzero;
   assign w_fail_mask = w_nonzero | r_uflow | r_oflow;

   // Sticky error masks; a new error in the clear cycle survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uflow <= '0;
         r_oflow <= '0;
      end else if (err_clr) begin
         r_uflow <= w_uflow_evt;
         r_oflow <= w_oflow_evt;
      end else begin
         r_uflow <= r_uflow | w_uflow_evt;
         r_oflow <= r_oflow | w_oflow_evt;
      end
   end

   // Check sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and control decode for the check sequencer.
   always_comb begin
      w_state_next = r_state;
      w_load_timer = 1'b0;
      w_dec_timer  = 1'b0;
      w_done       = 1'b0;
      w_busy       = 1'b0;
      w_ack        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (chk_req) begin
               w_state_next = S_DRAIN;
               w_load_timer = 1'b1;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_all_zero || (r_timer == '0)) begin
               w_state_next = S_REPORT;
               w_done       = 1'b1;
            end else begin
               w_dec_timer = 1'b1;
            end
         end
         S_REPORT: begin
            w_ack        = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Drain budget timer: loaded on request, counts down while waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (w_load_timer) begin
         r_timer <= chk_timeout;
      end else if (w_dec_timer) begin
         r_timer <= r_timer - 1'b1;
      end
   end

   // Result capture at drain exit; held until the next completed check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pass      <= 1'b0;
         r_fail_mask <= '0;
      end else if (w_done) begin
         r_pass      <= (w_fail_mask == '0);
         r_fail_mask <= w_fail_mask;
      end
   end

   assign chk_busy        = w_busy;
   assign chk_ack         = w_ack;
   assign chk_pass        = r_pass;
   assign chk_fail_mask   = r_fail_mask;
   assign err_uflow       = r_uflow;
   assign err_oflow       = r_oflow;
   assign outstanding_any = ~w_all_zero;

endmodule

// File: tb/tb_hqm_event_balance_ctrl.sv
// Self-checking bench for hqm_event_balance_ctrl: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_hqm_event_balance_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 2;
   localparam int TMO_W  = 16;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] in_event;
   logic [NUM_CH-1:0] out_event;
   logic              chk_req;
   logic [TMO_W-1:0]  chk_timeout;
   logic              err_clr;
   logic              chk_busy;
   logic              chk_ack;
   logic              chk_pass;
   logic [NUM_CH-1:0] chk_fail_mask;
   logic [NUM_CH-1:0] err_uflow;
   logic [NUM_CH-1:0] err_oflow;
   logic              outstanding_any;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   int                m_cnt [NUM_CH];
   logic [NUM_CH-1:0] m_uf, m_of, m_mask;
   logic              m_pass, m_busy, m_ack;
   int                m_timer;

   hqm_event_balance_ctrl #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TMO_W(TMO_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_event(in_event), .out_event(out_event),
      .chk_req(chk_req), .chk_timeout(chk_timeout), .err_clr(err_clr),
      .chk_busy(chk_busy), .chk_ack(chk_ack), .chk_pass(chk_pass),
      .chk_fail_mask(chk_fail_mask), .err_uflow(err_uflow),
      .err_oflow(err_oflow), .outstanding_any(outstanding_any)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      m_uf = '0; m_of = '0; m_mask = '0;
      m_pass = 1'b0; m_busy = 1'b0; m_ack = 1'b0; m_timer = 0;
   endfunction

   function automatic logic m_any();
      logic a = 1'b0;
      for (int i = 0; i < NUM_CH; i++) if (m_cnt[i] != 0) a = 1'b1;
      return a;
   endfunction

   // One clock edge of the reference behaviour, using pre-edge state.
   function automatic void model_step(input logic [NUM_CH-1:0] ie,
                                      input logic [NUM_CH-1:0] oe,
                                      input logic rq, input int tmo,
                                      input logic clr);
      logic [NUM_CH-1:0] nz, uf_e, of_e;
      for (int i = 0; i < NUM_CH; i++) nz[i] = (m_cnt[i] != 0);
      uf_e = '0; of_e = '0;
      if (m_ack) begin
         m_ack = 1'b0;
      end else if (m_busy) begin
         if (nz == '0 || m_timer == 0) begin
            m_mask = nz | m_uf | m_of;
            m_pass = (m_mask == '0);
            m_busy = 1'b0;
            m_ack  = 1'b1;
         end else begin
            m_timer = m_timer - 1;
         end
      end else if (rq) begin
         m_busy  = 1'b1;
         m_timer = tmo;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (ie[i] && !oe[i]) begin
            if (m_cnt[i] == CMAX) of_e[i] = 1'b1;
            else m_cnt[i] = m_cnt[i] + 1;
         end else if (oe[i] && !ie[i]) begin
            if (m_cnt[i] == 0) uf_e[i] = 1'b1;
            else m_cnt[i] = m_cnt[i] - 1;
         end
      end
      m_uf = clr ? uf_e : (m_uf | uf_e);
      m_of = clr ? of_e : (m_of | of_e);
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, sample at +1.
   task automatic cycle(input logic [NUM_CH-1:0] ie, input logic [NUM_CH-1:0] oe,
                        input logic rq, input int tmo, input logic clr);
      in_event = ie; out_event = oe; chk_req = rq;
      chk_timeout = TMO_W'(tmo); err_clr = clr;
      @(posedge clk);
      model_step(ie, oe, rq, tmo, clr);
      #1;
      in_event = '0; out_event = '0; chk_req = 1'b0; err_clr = 1'b0;
      chk_timeout = TMO_W'($urandom_range(0, 50));
   endtask

   task automatic apply_reset();
      in_event = '0; out_event = '0; chk_req = 1'b0;
      chk_timeout = '0; err_clr = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] obs;
      in_event = '0; out_event = '0; chk_req = 1'b0;
      chk_timeout = '0; err_clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      obs = {chk_busy, chk_ack, chk_pass, chk_fail_mask, err_uflow, err_oflow, outstanding_any};
      n_cmp++;
      if (obs !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0000", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      obs = {chk_busy, chk_ack, chk_pass, chk_fail_mask, err_uflow, err_oflow, outstanding_any};
      n_cmp++;
      if (obs !== 16'h0) begin
         n_fail++;
         $display("FAIL post_reset_outputs: got %h expected 0000", obs);
      end
      $display("test_reset done");
   endtask

   task automatic test_idle_pass();
      apply_reset();
      cycle('0, '0, 1'b1, 5, 1'b0);
      n_cmp++;
      if ({chk_busy, chk_ack} !== 2'b10) begin
         n_fail++;
         $display("FAIL idle_pass_c1: busy/ack %b expected 10", {chk_busy, chk_ack});
      end
      cycle('0, '0, 1'b0, 0, 1'b0);
      n_cmp++;
      if ({chk_busy, chk_ack, chk_pass, chk_fail_mask} !== 7'b0110000) begin
         n_fail++;
         $display("FAIL idle_pass_c2: busy/ack/pass/mask %b expected 0110000",
                  {chk_busy, chk_ack, chk_pass, chk_fail_mask});
      end
      cycle('0, '0, 1'b0, 0, 1'b0);
      n_cmp++;
      if ({chk_ack, chk_pass} !== 2'b01) begin
         n_fail++;
         $display("FAIL idle_pass_hold: ack/pass %b expected 01", {chk_ack, chk_pass});
      end
      $display("test_idle_pass done");
   endtask

   task automatic test_ch0_fail();
      int busy_cycles = 0;
      apply_reset();
      repeat (3) cycle(4'b0001, '0, 1'b0, 0, 1'b0);
      cycle('0, '0, 1'b1, 4, 1'b0);
      for (int k = 0; k < 20 && !chk_ack; k++) begin
         if (chk_busy) busy_cycles++;
         cycle('0, '0, 1'b0, 0, 1'b0);
      end
      n_cmp++;
      if (chk_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL ch0_ack_timeout: ack %b expected 1", chk_ack);
      end
      n_cmp++;
      if (busy_cycles != 5) begin
         n_fail++;
         $display("FAIL ch0_busy_len: got %0d expected 5", busy_cycles);
      end
      n_cmp++;
      if ({chk_pass, chk_fail_mask, outstanding_any} !== 6'b000011) begin
         n_fail++;
         $display("FAIL ch0_result: pass/mask/any %b expected 000011",
                  {chk_pass, chk_fail_mask, outstanding_any});
      end
      $display("test_ch0_fail done busy=%0d", busy_cycles);
   endtask

   task automatic test_ch2_drain();
      int cyc = 1;
      int ack_cyc = -1;
      apply_reset();
      repeat (2) cycle(4'b0100, '0, 1'b0, 0, 1'b0);
      cycle('0, '0, 1'b1, 10, 1'b0);
      while (cyc < 20) begin
         if (chk_ack && ack_cyc < 0) ack_cyc = cyc;
         cycle('0, (cyc == 3 || cyc == 5) ? 4'b0100 : 4'b0000, 1'b0, 0, 1'b0);
         cyc++;
      end
      n_cmp++;
      if (ack_cyc != 7) begin
         n_fail++;
         $display("FAIL ch2_ack_cycle: got %0d expected 7", ack_cyc);
      end
      n_cmp++;
      if ({chk_pass, chk_fail_mask} !== 5'b10000) begin
         n_fail++;
         $display("FAIL ch2_result: pass/mask %b expected 10000", {chk_pass, chk_fail_mask});
      end
      $display("test_ch2_drain done ack_cycle=%0d", ack_cyc);
   endtask

   task automatic test_uflow();
      apply_reset();
      cycle('0, 4'b0010, 1'b0, 0, 1'b0);
      n_cmp++;
      if ({err_uflow, outstanding_any} !== 5'b00100) begin
         n_fail++;
         $display("FAIL uflow_set: uflow/any %b expected 00100", {err_uflow, outstanding_any});
      end
      cycle('0, '0, 1'b1, 0, 1'b0);
      cycle('0, '0, 1'b0, 0, 1'b0);
      n_cmp++;
      if ({chk_ack, chk_pass, chk_fail_mask} !== 6'b100010) begin
         n_fail++;
         $display("FAIL uflow_check: ack/pass/mask %b expected 100010",
                  {chk_ack, chk_pass, chk_fail_mask});
      end
      cycle('0, 4'b0010, 1'b0, 0, 1'b1);
      n_cmp++;
      if (err_uflow !== 4'b0010) begin
         n_fail++;
         $display("FAIL uflow_clr_race: got %b expected 0010", err_uflow);
      end
      cycle('0, '0, 1'b0, 0, 1'b1);
      n_cmp++;
      if (err_uflow !== 4'b0000) begin
         n_fail++;
         $display("FAIL uflow_clear: got %b expected 0000", err_uflow);
      end
      $display("test_uflow done");
   endtask

   task automatic test_oflow();
      apply_reset();
      repeat (4) cycle(4'b1000, '0, 1'b0, 0, 1'b0);
      n_cmp++;
      if ({err_oflow, outstanding_any} !== 5'b10001) begin
         n_fail++;
         $display("FAIL oflow_set: oflow/any %b expected 10001", {err_oflow, outstanding_any});
      end
      cycle(4'b1000, 4'b1000, 1'b0, 0, 1'b0);
      repeat (2) cycle('0, 4'b1000, 1'b0, 0, 1'b0);
      n_cmp++;
      if (outstanding_any !== 1'b1) begin
         n_fail++;
         $display("FAIL oflow_hold_2: any %b expected 1", outstanding_any);
      end
      cycle('0, 4'b1000, 1'b0, 0, 1'b0);
      n_cmp++;
      if ({outstanding_any, err_uflow} !== 5'b00000) begin
         n_fail++;
         $display("FAIL oflow_drain_3: any/uflow %b expected 00000", {outstanding_any, err_uflow});
      end
      $display("test_oflow done");
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      logic [15:0] obs;
      apply_reset();
      cycle(4'b0001, '0, 1'b0, 0, 1'b0);
      cycle('0, '0, 1'b1, 10, 1'b0);
      cycle('0, '0, 1'b0, 0, 1'b0);
      n_cmp++;
      if (chk_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_busy: got %b expected 1", chk_busy);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      obs = {chk_busy, chk_ack, chk_pass, chk_fail_mask, err_uflow, err_oflow, outstanding_any};
      n_cmp++;
      if (obs !== 16'h0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %h expected 0000", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 6; k++) begin
         if (chk_ack) acks++;
         cycle('0, '0, 1'b0, 0, 1'b0);
      end
      n_cmp++;
      if (acks != 0) begin
         n_fail++;
         $display("FAIL midrst_no_ack: got %0d acks expected 0", acks);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      apply_reset();
      cycle(4'b0001, '0, 1'b0, 0, 1'b0);
      cycle('0, '0, 1'b1, 3, 1'b0);
      for (int k = 0; k < 15; k++) begin
         if (chk_ack) acks++;
         cycle('0, '0, chk_busy, 0, 1'b0);
      end
      n_cmp++;
      if (acks != 1) begin
         n_fail++;
         $display("FAIL req_while_busy: got %0d acks expected 1", acks);
      end
      $display("test_back_to_back done acks=%0d", acks);
   endtask

   task automatic test_random();
      logic [15:0] obs, exp;
      int bad = 0;
      apply_reset();
      for (int k = 0; k < 600; k++) begin
         cycle(NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15)),
               NUM_CH'($urandom_range(0, 15) & $urandom_range(0, 15)),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 8),
               ($urandom_range(0, 31) == 0));
         obs = {chk_busy, chk_ack, chk_pass, chk_fail_mask, err_uflow, err_oflow, outstanding_any};
         exp = {m_busy, m_ack, m_pass, m_mask, m_uf, m_of, m_any()};
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            bad++;
            $display("FAIL random_cycle_%0d: got %b expected %b", k, obs, exp);
         end
      end
      $display("test_random done errors=%0d", bad);
   endtask

   initial begin
      test_reset();
      test_idle_pass();
      test_ch0_fail();
      test_ch2_drain();
      test_uflow();
      test_oflow();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hqm_event_balance_ctrl.md
Name: hqm_event_balance_ctrl

Overview:
Single-clock controller that tracks per-channel outstanding events (start events minus end events) and sequences on-demand drain checks. On request it waits a programmable number of cycles for every channel to drain to zero, then reports pass/fail with a per-channel failure mask. Sits next to producer/consumer pairs as a quiesce-time balance checker; it also flags dropped or duplicated events through sticky underflow/overflow masks.

Parameters:
NUM_CH, 4, number of independent event channels (>=1)
CNT_W, 8, width of each per-channel outstanding counter
TMO_W, 16, width of the drain timeout value

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_event  input  NUM_CH  per-channel start event, one pulse per event
out_event  input  NUM_CH  per-channel end event, one pulse per event
chk_req  input  1  start a drain check (pulse; sampled only in IDLE)
chk_timeout  input  TMO_W  drain wait budget in cycles, sampled with chk_req
err_clr  input  1  clear sticky error masks
chk_busy  output  1  check in progress (DRAIN state)
chk_ack  output  1  one-cycle pulse: check result valid
chk_pass  output  1  result of last completed check
chk_fail_mask  output  NUM_CH  failing channels of last completed check
err_uflow  output  NUM_CH  sticky: end event seen with count 0
err_oflow  output  NUM_CH  sticky: start event seen with count at max
outstanding_any  output  1  OR over channels of (count != 0), from registered counts

Behaviour:
- Reset: all counters 0, FSM IDLE, timer 0. All outputs 0 except outstanding_any, which is 0 because it is derived from the counts.
- Counter per channel i, updated every cycle, including during a check:
  - in=1, out=1: count unchanged, no error.
  - in only: count+1. If count == 2^CNT_W-1, hold the count and set err_oflow[i] next cycle.
  - out only: count-1. If count == 0, hold at 0 and set err_uflow[i] next cycle.
- Sticky masks:
  - err_clr clears both masks next cycle.
  - An error on the same cycle as err_clr wins, so its bit ends up 1.
- FSM states: IDLE, DRAIN, REPORT.
  - IDLE: chk_req=1 moves to DRAIN next cycle and loads timer = chk_timeout. chk_busy=1 from that cycle.
  - DRAIN: evaluate the registered counts each cycle.
    - All counts 0: go to REPORT with pass.
    - Otherwise, timer==0: go to REPORT with fail.
    - Otherwise: decrement timer and stay.
    - chk_timeout=0 gives exactly one evaluation cycle.
    - Maximum DRAIN residency is chk_timeout+1 cycles.
  - REPORT (1 cycle): chk_ack=1 and chk_busy=0. On this cycle chk_pass and chk_fail_mask update.
    - chk_fail_mask[i] = (count[i]!=0) | err_uflow[i] | err_oflow[i], using values at DRAIN exit.
    - chk_pass = (chk_fail_mask == 0).
    - Next state is always IDLE.
- chk_pass and chk_fail_mask hold until the next REPORT. They are not cleared by chk_req or err_clr.
- chk_req in DRAIN or REPORT is ignored, with no queueing.
- Latency: a chk_req with all channels already drained gives chk_ack 2 cycles after chk_req (IDLE->DRAIN->REPORT).
- Asynchronous reset mid-check returns to IDLE with no chk_ack. Results and masks clear to 0.
- chk_timeout changes outside the chk_req cycle have no effect.

Test Plan:
- Reset, no events, chk_req with chk_timeout=5 -> chk_ack at cycle +2, chk_pass=1, chk_fail_mask=0.
- Ch0: 3 in_event, no out_event; chk_req with timeout=4 -> chk_busy for 5 cycles, chk_ack, chk_pass=0, chk_fail_mask=4'b0001.
- Ch2: 2 in_event, chk_req with timeout=10, 2 out_event on cycles +3 and +5 -> chk_ack on cycle +7, chk_pass=1.
- out_event[1] with count 0 -> err_uflow=4'b0010, count stays 0. Next check: chk_fail_mask=4'b0010. err_clr concurrent with a new uflow on ch1 -> bit stays 1.
- CNT_W=2: ch3 sees 4 in_event -> count holds at 3 and err_oflow[3]=1. Same-cycle in+out on ch3 -> count unchanged.
- Assert rst_n low during DRAIN -> no chk_ack, all outputs 0. chk_req while chk_busy -> ignored, exactly one chk_ack.
